// File: rtl/nebula_trap_if.sv
// Commit-stage / CSR-file side of the trap unit: event inputs, CSR state and
// trap/redirect outputs bundled so the trap unit connects through one port.
interface nebula_trap_if #(
  parameter int XLEN = 64
);
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic [XLEN-1:0] next_pc;
  logic            exc_valid;
  logic [3:0]      exc_code;
  logic [XLEN-1:0] exc_tval;
  logic            mret_valid;
  logic            mie_global;
  logic [XLEN-1:0] mie_en;
  logic [XLEN-1:0] mip;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic            debug_mode;
  logic            trap;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] trap_value;
  logic            flush;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            mret_done;
  logic            busy;

  modport master (
    output commit_valid, commit_pc, next_pc, exc_valid, exc_code, exc_tval,
           mret_valid, mie_global, mie_en, mip, mtvec, mepc, debug_mode,
    input  trap, trap_cause, trap_pc, trap_value, flush, redirect_valid,
           redirect_pc, mret_done, busy
  );

  modport slave (
    input  commit_valid, commit_pc, next_pc, exc_valid, exc_code, exc_tval,
           mret_valid, mie_global, mie_en, mip, mtvec, mepc, debug_mode,
    output trap, trap_cause, trap_pc, trap_value, flush, redirect_valid,
           redirect_pc, mret_done, busy
  );
endinterface

// File: rtl/nebula_trap_unit.sv
// Trap sequencer in front of the CSR file: arbitrates exceptions, MRET and
// machine interrupts at commit, then strobes trap/flush and redirects fetch.
module nebula_trap_unit #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] IRQ_MASK = XLEN'(64'h0000_0000_0000_0888)
) (
  input logic         clk,
  input logic         rst,
  nebula_trap_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRAP  = 2'd1,
    S_REDIR = 2'd2,
    S_MRET  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic            irq_q, irq_d;
  logic [5:0]      code_q, code_d;
  logic            trap_q, trap_d;
  logic            flush_q, flush_d;
  logic            rvalid_q, rvalid_d;
  logic            mret_done_q, mret_done_d;
  logic            busy_q, busy_d;
  logic [XLEN-1:0] pend_s;
  logic [XLEN-1:0] base_s;
  logic [XLEN-1:0] rpc_s;

  // Interrupt code: MEI > MSI > MTI; any other enabled source falls back to its bit index.
  function automatic logic [5:0] irq_code(input logic [XLEN-1:0] pend);
    logic [5:0] code;
    code = 6'd0;
    for (int i = 0; i < XLEN; i++) begin
      code = pend[i] ? 6'(i) : code;
    end
    code = pend[7]  ? 6'd7  : code;
    code = pend[3]  ? 6'd3  : code;
    code = pend[11] ? 6'd11 : code;
    return code;
  endfunction

  assign pend_s = bus.mip & bus.mie_en & IRQ_MASK;
  assign base_s = {bus.mtvec[XLEN-1:2], 2'b00};

  // Event arbitration, next state and next values of the registered strobes.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    pc_d    = pc_q;
    tval_d  = tval_q;
    irq_d   = irq_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (bus.commit_valid && !bus.debug_mode) begin
          if (bus.exc_valid) begin
            state_d = S_TRAP;
            cause_d = {{(XLEN-4){1'b0}}, bus.exc_code};
            pc_d    = bus.commit_pc;
            tval_d  = bus.exc_tval;
            irq_d   = 1'b0;
            code_d  = 6'd0;
          end else if (bus.mret_valid) begin
            state_d = S_MRET;
          end else if (bus.mie_global && (pend_s != {XLEN{1'b0}})) begin
            state_d = S_TRAP;
            code_d  = irq_code(pend_s);
            cause_d = {1'b1, {(XLEN-7){1'b0}}, irq_code(pend_s)};
            pc_d    = bus.next_pc;
            tval_d  = {XLEN{1'b0}};
            irq_d   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TRAP:  state_d = S_REDIR;
      S_REDIR: state_d = S_IDLE;
      S_MRET:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    trap_d      = (state_d == S_TRAP);
    flush_d     = (state_d == S_TRAP) || (state_d == S_MRET);
    rvalid_d    = (state_d == S_REDIR) || (state_d == S_MRET);
    mret_done_d = (state_d == S_MRET);
    busy_d      = (state_d != S_IDLE);
  end

  // mtvec is read live in REDIR so the redirect sees the CSR state after the trap.
  always_comb begin
    rpc_s = {XLEN{1'b0}};
    if (state_q == S_REDIR) begin
      if (irq_q && (bus.mtvec[1:0] == 2'b01)) begin
        rpc_s = base_s + {{(XLEN-8){1'b0}}, code_q, 2'b00};
      end else begin
        rpc_s = base_s;
      end
    end else if (state_q == S_MRET) begin
      rpc_s = bus.mepc;
    end else begin
      rpc_s = {XLEN{1'b0}};
    end
  end

  // State and output registers; reset aborts any sequence in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cause_q     <= {XLEN{1'b0}};
      pc_q        <= {XLEN{1'b0}};
      tval_q      <= {XLEN{1'b0}};
      irq_q       <= 1'b0;
      code_q      <= 6'd0;
      trap_q      <= 1'b0;
      flush_q     <= 1'b0;
      rvalid_q    <= 1'b0;
      mret_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      pc_q        <= pc_d;
      tval_q      <= tval_d;
      irq_q       <= irq_d;
      code_q      <= code_d;
      trap_q      <= trap_d;
      flush_q     <= flush_d;
      rvalid_q    <= rvalid_d;
      mret_done_q <= mret_done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.trap           = trap_q;
  assign bus.trap_cause     = cause_q;
  assign bus.trap_pc        = pc_q;
  assign bus.trap_value     = tval_q;
  assign bus.flush          = flush_q;
  assign bus.redirect_valid = rvalid_q;
  assign bus.redirect_pc    = rpc_s;
  assign bus.mret_done      = mret_done_q;
  assign bus.busy           = busy_q;

endmodule
